fifo_frame_reader: RTL and testbench



---
 rtl/fifo_frame_reader.sv | 163 ++++++++++++++++
 tb/tb_fifo_frame_reader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_reader.sv
// Frame reader for the ping-pong sample FIFO: arms write mode, waits for a full frame, strobes it
// out with rd_clk and reports max/min (and mean when FRAME_MEAN_EN is defined) with a valid pulse.
module fifo_frame_reader #(
    parameter int DATA_W  = 12,
    parameter int DEPTH   = 1000,
    parameter int CNT_W   = 10,
    parameter int RD_HALF = 2
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic              run,
    input  logic              wr_full,
    input  logic              rd_empty,
    input  logic [DATA_W-1:0] data_fifo_out,
    output logic              wr_en,
    output logic              rd_en,
    output logic              rd_clk,
    output logic              busy,
    output logic              stat_valid,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] mean_val
);

    localparam int SUM_W = DATA_W + CNT_W;
    localparam int PH_W  = $clog2(RD_HALF + 3);

`ifdef FRAME_MEAN_EN
    typedef enum logic [2:0] {IDLE, ARM_WR, WAIT_FULL, START_RD, RD_HI, RD_LO, DIV, DONE} state_t;
    localparam int DC_W = $clog2(SUM_W + 1);
`else
    typedef enum logic [2:0] {IDLE, ARM_WR, WAIT_FULL, START_RD, RD_HI, RD_LO, DONE} state_t;
`endif

    state_t            state, state_n;
    logic [PH_W-1:0]   phase;
    logic [CNT_W:0]    cnt, cnt_inc;
    logic [DATA_W-1:0] max_acc, min_acc, max_nx, min_nx;
    logic              last_ph, frame_end;

    assign last_ph   = (phase == PH_W'(RD_HALF - 1));
    assign cnt_inc   = cnt + 1'b1;
    assign frame_end = (cnt_inc == (CNT_W+1)'(DEPTH));
    assign max_nx    = (data_fifo_out > max_acc) ? data_fifo_out : max_acc;
    assign min_nx    = (data_fifo_out < min_acc) ? data_fifo_out : min_acc;

`ifdef FRAME_MEAN_EN
    logic [SUM_W-1:0] sum_acc, sum_nx, dvd, rem, rem_nx;
    logic [SUM_W:0]   rem_sh;
    logic [DC_W-1:0]  div_cnt;
    logic             q_bit;

    assign sum_nx = sum_acc + SUM_W'(data_fifo_out);
    // One restoring step per cycle; quotient bits shift into the dividend register.
    assign rem_sh = {rem, dvd[SUM_W-1]};
    assign q_bit  = (rem_sh >= (SUM_W+1)'(DEPTH));
    assign rem_nx = q_bit ? SUM_W'(rem_sh - (SUM_W+1)'(DEPTH)) : rem_sh[SUM_W-1:0];
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (run && rd_empty) state_n = ARM_WR;
            ARM_WR:    state_n = WAIT_FULL;
            WAIT_FULL: begin
                if (wr_full)   state_n = START_RD;
                else if (!run) state_n = IDLE;
            end
            START_RD:  if (phase == PH_W'(2)) state_n = RD_HI;
            RD_HI:     if (last_ph) state_n = RD_LO;
            RD_LO: begin
                if (last_ph) begin
`ifdef FRAME_MEAN_EN
                    state_n = frame_end ? DIV : RD_HI;
`else
                    state_n = frame_end ? DONE : RD_HI;
`endif
                end
            end
`ifdef FRAME_MEAN_EN
            DIV:       if (div_cnt == DC_W'(SUM_W)) state_n = DONE;
`endif
            DONE:      state_n = (run && rd_empty) ? ARM_WR : IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Strobe/mode outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            cnt        <= '0;
            max_acc    <= '0;
            min_acc    <= '0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            rd_clk     <= 1'b0;
            busy       <= 1'b0;
            stat_valid <= 1'b0;
            max_val    <= '0;
            min_val    <= '0;
        end else begin
            state      <= state_n;
            phase      <= (state_n != state) ? '0 : phase + 1'b1;
            wr_en      <= (state_n == ARM_WR) || (state_n == WAIT_FULL);
            rd_en      <= (state_n == START_RD) || (state_n == RD_HI) || (state_n == RD_LO);
            rd_clk     <= (state_n == RD_HI);
            busy       <= (state_n != IDLE);
            stat_valid <= (state_n == DONE);
            if (state == START_RD) begin
                cnt     <= '0;
                max_acc <= '0;
                min_acc <= '1;
            end
            if (state == RD_LO && last_ph) begin
                cnt     <= cnt_inc;
                max_acc <= max_nx;
                min_acc <= min_nx;
            end
`ifdef FRAME_MEAN_EN
            if (state == DIV && state_n == DONE) begin
                max_val <= max_acc;
                min_val <= min_acc;
            end
`else
            if (state == RD_LO && state_n == DONE) begin
                max_val <= max_nx;
                min_val <= min_nx;
            end
`endif
        end
    end

`ifdef FRAME_MEAN_EN
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            sum_acc  <= '0;
            dvd      <= '0;
            rem      <= '0;
            div_cnt  <= '0;
            mean_val <= '0;
        end else begin
            if (state == START_RD) sum_acc <= '0;
            if (state == RD_LO && last_ph) sum_acc <= sum_nx;
            if (state == RD_LO && state_n == DIV) begin
                dvd     <= sum_nx;
                rem     <= '0;
                div_cnt <= '0;
            end
            if (state == DIV && div_cnt != DC_W'(SUM_W)) begin
                dvd     <= {dvd[SUM_W-2:0], q_bit};
                rem     <= rem_nx;
                div_cnt <= div_cnt + 1'b1;
            end
            if (state == DIV && state_n == DONE) mean_val <= dvd[DATA_W-1:0];
        end
    end
`else
    assign mean_val = '0;
`endif

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader with a small ping-pong FIFO model (DEPTH=8, RD_HALF=2).
module tb_fifo_frame_reader;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 3;
`ifdef FRAME_MEAN_EN
    localparam bit MEAN_ON = 1'b1;
`else
    localparam bit MEAN_ON = 1'b0;
`endif
    // stat_valid cycle minus the cycle rd_clk last fell (T = fall + 1)
    localparam int EXP_LAT = MEAN_ON ? (1 + 2 + DATA_W + CNT_W) : 2;

    logic              clk_100M = 1'b0;
    logic              rst = 1'b1, run = 1'b0;
    logic              wr_full, rd_empty;
    logic [DATA_W-1:0] data_fifo_out;
    logic              wr_en, rd_en, rd_clk, busy, stat_valid;
    logic [DATA_W-1:0] max_val, min_val, mean_val;

    fifo_frame_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .RD_HALF(2)) dut (
        .clk_100M(clk_100M), .rst(rst), .run(run), .wr_full(wr_full), .rd_empty(rd_empty),
        .data_fifo_out(data_fifo_out), .wr_en(wr_en), .rd_en(rd_en), .rd_clk(rd_clk),
        .busy(busy), .stat_valid(stat_valid), .max_val(max_val), .min_val(min_val),
        .mean_val(mean_val)
    );

    always #5 clk_100M = ~clk_100M;

    // FIFO model: fills 4 cycles into write mode, registered read data on rd_clk rise.
    logic [DATA_W-1:0] mem [DEPTH];
    logic              hold_full = 1'b0;
    logic              rdc_d = 1'b0;
    int                rptr = 0, wcnt = 0;
    initial begin wr_full = 1'b0; rd_empty = 1'b1; data_fifo_out = '0; end

    always @(posedge clk_100M) begin
        rdc_d <= rd_clk;
        if (rst) begin
            wr_full <= 1'b0; rd_empty <= 1'b1; rptr <= 0; wcnt <= 0;
        end else begin
            if (wr_en) begin
                wcnt <= wcnt + 1;
                if (wcnt == 4 && !hold_full) begin
                    wr_full <= 1'b1; rd_empty <= 1'b0; rptr <= 0;
                end
            end else wcnt <= 0;
            if (rd_clk && !rdc_d && rptr < DEPTH) begin
                data_fifo_out <= mem[rptr];
                rptr <= rptr + 1;
                if (rptr == DEPTH - 1) begin wr_full <= 1'b0; rd_empty <= 1'b1; end
            end
        end
    end

    // Event monitor, sampled on the inactive edge.
    int cyc = 0, rise_cnt = 0, rden_rise = 0, sv_cnt = 0, sv_cyc = 0, last_fall = 0, overlap = 0;
    logic rdc_n = 1'b0, rden_n = 1'b0;
    always @(posedge clk_100M) cyc <= cyc + 1;
    always @(negedge clk_100M) begin
        rdc_n  <= rd_clk;
        rden_n <= rd_en;
        if (rd_clk && !rdc_n) rise_cnt <= rise_cnt + 1;
        if (!rd_clk && rdc_n) last_fall <= cyc;
        if (rd_en && !rden_n) rden_rise <= rden_rise + 1;
        if (stat_valid) begin sv_cnt <= sv_cnt + 1; sv_cyc <= cyc; end
        if (wr_en && rd_en) overlap <= overlap + 1;
    end

    int nvec = 0, nerr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame(input int drop_at);
        int r0, s0;
        bit got;
        r0 = rise_cnt; s0 = sv_cnt; got = 1'b0; run = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk_100M);
            if (drop_at >= 0 && rise_cnt - r0 >= drop_at) run = 1'b0;
            if (stat_valid) begin got = 1'b1; run = 1'b0; end
        end
        check("stat_valid_seen", 32'(got), 1);
        repeat (6) @(negedge clk_100M);
        check("rd_clk_rises", rise_cnt - r0, DEPTH);
        check("stat_valid_cycles", sv_cnt - s0, 1);
        check("stat_valid_latency", sv_cyc - last_fall, EXP_LAT);
        check("busy_after_frame", 32'(busy), 0);
    endtask

    task automatic check_stats(input string tag, input int mx, input int mn, input int mean);
        check({tag, "_max"}, 32'(max_val), mx);
        check({tag, "_min"}, 32'(min_val), mn);
        check({tag, "_mean"}, 32'(mean_val), MEAN_ON ? mean : 0);
    endtask

    initial begin
        int r0, s0;
        bit got;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
        repeat (3) @(negedge clk_100M);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_rd_clk", 32'(rd_clk), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_stat_valid", 32'(stat_valid), 0);
        check_stats("rst", 0, 0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk_100M);

        // ramp 0..7
        frame(-1);
        check_stats("ramp", 7, 0, 3);

        // all ones
        for (int i = 0; i < DEPTH; i++) mem[i] = 12'hFFF;
        frame(-1);
        check_stats("allff", 4095, 4095, 4095);

        // run dropped after the third sample strobe
        for (int i = 0; i < DEPTH; i++) mem[i] = (i < 4) ? 12'd5 : 12'd9;
        frame(3);
        check_stats("drop3", 9, 5, 7);

        // run dropped in WAIT_FULL
        hold_full = 1'b1;
        r0 = rden_rise; s0 = sv_cnt; got = 1'b0; run = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_100M);
            if (wr_en) got = 1'b1;
        end
        check("wf_wr_en_seen", 32'(got), 1);
        repeat (4) @(negedge clk_100M);
        run = 1'b0;
        @(negedge clk_100M);
        check("wf_wr_en_drop", 32'(wr_en), 0);
        check("wf_busy", 32'(busy), 0);
        repeat (20) @(negedge clk_100M);
        check("wf_rd_en_edges", rden_rise - r0, 0);
        check("wf_stat_valid", sv_cnt - s0, 0);
        hold_full = 1'b0;

        // reset while rd_clk is high
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
        r0 = rise_cnt; got = 1'b0; run = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk_100M);
            if (rd_clk && rise_cnt - r0 >= 2) got = 1'b1;
        end
        check("rhi_reached", 32'(got), 1);
        rst = 1'b1;
        @(negedge clk_100M);
        check("rhi_rd_clk", 32'(rd_clk), 0);
        check("rhi_rd_en", 32'(rd_en), 0);
        check("rhi_busy", 32'(busy), 0);
        check_stats("rhi", 0, 0, 0);
        rst = 1'b0;
        frame(-1);
        check_stats("after_rst", 7, 0, 3);

        check("wr_rd_overlap", overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
